// File: rtl/bip_pkg.sv
// Shared encodings for the BIP control unit: opcodes, mux selects,
// ALU operations, FSM states and the decoded control bundle.
package bip_pkg;

    localparam logic [4:0] OP_HLT  = 5'b00000;
    localparam logic [4:0] OP_STO  = 5'b00001;
    localparam logic [4:0] OP_LD   = 5'b00010;
    localparam logic [4:0] OP_LDI  = 5'b00011;
    localparam logic [4:0] OP_ADD  = 5'b00100;
    localparam logic [4:0] OP_ADDI = 5'b00101;
    localparam logic [4:0] OP_SUB  = 5'b00110;
    localparam logic [4:0] OP_SUBI = 5'b00111;

    localparam logic [1:0] SELA_MEM = 2'd0;
    localparam logic [1:0] SELA_IMM = 2'd1;
    localparam logic [1:0] SELA_ALU = 2'd2;

    localparam logic ALU_ADD = 1'b0;
    localparam logic ALU_SUB = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_MEM,
        ST_EXEC,
        ST_HALT
    } state_t;

    typedef struct packed {
        logic       needs_mem;
        logic [1:0] sel_a;
        logic       sel_b;
        logic       alu_op;
        logic       acc_en;
        logic       data_wr;
        logic       is_halt;
    } ctrl_t;

endpackage

// File: rtl/bip_decoder.sv
// Combinational opcode decoder: maps an opcode to the datapath controls
// used in EXEC plus the two flags the FSM needs in DECODE.
module bip_decoder
    import bip_pkg::*;
(
    input  logic [4:0] i_opcode,
    output ctrl_t      o_ctrl
);

    // Table lookup; unlisted opcodes fall through as NOPs with no strobes
    always_comb begin
        o_ctrl = '0;
        case (i_opcode)
            OP_HLT:  o_ctrl.is_halt = 1'b1;
            OP_STO:  o_ctrl.data_wr = 1'b1;
            OP_LD: begin
                o_ctrl.needs_mem = 1'b1;
                o_ctrl.sel_a     = SELA_MEM;
                o_ctrl.acc_en    = 1'b1;
            end
            OP_LDI: begin
                o_ctrl.sel_a  = SELA_IMM;
                o_ctrl.acc_en = 1'b1;
            end
            OP_ADD: begin
                o_ctrl.needs_mem = 1'b1;
                o_ctrl.sel_a     = SELA_ALU;
                o_ctrl.sel_b     = 1'b0;
                o_ctrl.alu_op    = ALU_ADD;
                o_ctrl.acc_en    = 1'b1;
            end
            OP_ADDI: begin
                o_ctrl.sel_a  = SELA_ALU;
                o_ctrl.sel_b  = 1'b1;
                o_ctrl.alu_op = ALU_ADD;
                o_ctrl.acc_en = 1'b1;
            end
            OP_SUB: begin
                o_ctrl.needs_mem = 1'b1;
                o_ctrl.sel_a     = SELA_ALU;
                o_ctrl.sel_b     = 1'b0;
                o_ctrl.alu_op    = ALU_SUB;
                o_ctrl.acc_en    = 1'b1;
            end
            OP_SUBI: begin
                o_ctrl.sel_a  = SELA_ALU;
                o_ctrl.sel_b  = 1'b1;
                o_ctrl.alu_op = ALU_SUB;
                o_ctrl.acc_en = 1'b1;
            end
            default: o_ctrl = '0;
        endcase
    end

endmodule

// File: rtl/bip_control.sv
// Multi-cycle control unit for the accumulator BIP datapath: fetches,
// decodes and sequences each instruction, owns the PC and a saturating
// busy-cycle counter.
module bip_control
    import bip_pkg::*;
#(
    parameter int PC_WIDTH     = 11,
    parameter int OPCODE_WIDTH = 5,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                start,
    input  logic [PC_WIDTH+OPCODE_WIDTH-1:0]    instr_data,
    output logic                                instr_rd,
    output logic [PC_WIDTH-1:0]                 pc_addr,
    output logic [PC_WIDTH-1:0]                 operand,
    output logic                                data_rd,
    output logic                                data_wr,
    output logic [1:0]                          sel_a,
    output logic                                sel_b,
    output logic                                alu_op,
    output logic                                acc_en,
    output logic                                busy,
    output logic                                halted,
    output logic [CNT_WIDTH-1:0]                cycle_count
);

    localparam int INSTR_W = PC_WIDTH + OPCODE_WIDTH;

    state_t                 r_state;
    state_t                 w_next;
    logic [PC_WIDTH-1:0]    r_pc;
    logic [INSTR_W-1:0]     r_instr;
    logic [CNT_WIDTH-1:0]   r_count;
    logic [OPCODE_WIDTH-1:0] w_opcode;
    ctrl_t                  w_ctrl;
    logic                   w_in_decode;

    // In DECODE the fresh memory word is not yet registered, so decode it directly
    assign w_in_decode = (r_state == ST_DECODE);
    assign w_opcode    = w_in_decode ? instr_data[INSTR_W-1:PC_WIDTH]
                                     : r_instr[INSTR_W-1:PC_WIDTH];

    bip_decoder u_decoder (
        .i_opcode (w_opcode),
        .o_ctrl   (w_ctrl)
    );

    assign pc_addr     = r_pc;
    assign operand     = w_in_decode ? instr_data[PC_WIDTH-1:0] : r_instr[PC_WIDTH-1:0];
    assign cycle_count = r_count;
    assign busy        = (r_state == ST_FETCH) || (r_state == ST_DECODE) ||
                         (r_state == ST_MEM)   || (r_state == ST_EXEC);
    assign halted      = (r_state == ST_HALT);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    // PC advances only at the end of EXEC; HLT never reaches EXEC so it freezes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                  r_pc <= '0;
        else if (r_state == ST_EXEC) r_pc <= r_pc + {{(PC_WIDTH-1){1'b0}}, 1'b1};
    end

    // Instruction register captures the word returned by the FETCH read
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)           r_instr <= '0;
        else if (w_in_decode) r_instr <= instr_data;
    end

    // Busy-cycle counter sticks at all ones instead of wrapping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                      r_count <= '0;
        else if (busy && (r_count != '1)) r_count <= r_count + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end

    // Next-state and strobe generation; strobes are zero unless the state drives them
    always_comb begin
        w_next   = r_state;
        instr_rd = 1'b0;
        data_rd  = 1'b0;
        data_wr  = 1'b0;
        sel_a    = SELA_MEM;
        sel_b    = 1'b0;
        alu_op   = ALU_ADD;
        acc_en   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) w_next = ST_FETCH;
            end
            ST_FETCH: begin
                instr_rd = 1'b1;
                w_next   = ST_DECODE;
            end
            ST_DECODE: begin
                if (w_ctrl.is_halt) begin
                    w_next = ST_HALT;
                end else if (w_ctrl.needs_mem) begin
                    data_rd = 1'b1;
                    w_next  = ST_MEM;
                end else begin
                    w_next = ST_EXEC;
                end
            end
            ST_MEM: begin
                w_next = ST_EXEC;
            end
            ST_EXEC: begin
                sel_a   = w_ctrl.sel_a;
                sel_b   = w_ctrl.sel_b;
                alu_op  = w_ctrl.alu_op;
                acc_en  = w_ctrl.acc_en;
                data_wr = w_ctrl.data_wr;
                w_next  = ST_FETCH;
            end
            ST_HALT: begin
                w_next = ST_HALT;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_bip_control.sv
// Testbench for bip_control: directed programs plus a random program, all
// checked cycle by cycle against an instruction-level reference model.
module tb_bip_control;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] instr_data;
    logic        instr_rd;
    logic [10:0] pc_addr;
    logic [10:0] operand;
    logic        data_rd;
    logic        data_wr;
    logic [1:0]  sel_a;
    logic        sel_b;
    logic        alu_op;
    logic        acc_en;
    logic        busy;
    logic        halted;
    logic [15:0] cycle_count;

    logic [15:0] progMem [0:2047];

    int          checks = 0;
    int          errors = 0;

    logic [10:0] mPc;
    logic [10:0] mLastOp;
    logic [15:0] mCount;

    bip_control dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .instr_data  (instr_data),
        .instr_rd    (instr_rd),
        .pc_addr     (pc_addr),
        .operand     (operand),
        .data_rd     (data_rd),
        .data_wr     (data_wr),
        .sel_a       (sel_a),
        .sel_b       (sel_b),
        .alu_op      (alu_op),
        .acc_en      (acc_en),
        .busy        (busy),
        .halted      (halted),
        .cycle_count (cycle_count)
    );

    // Free-running 100 MHz clock
    always #5 clk = ~clk;

    // Program memory with one-cycle synchronous read
    always @(posedge clk) begin
        if (instr_rd) instr_data <= progMem[pc_addr];
    end

    function automatic logic [63:0] packOut(
        input logic ird, input logic drd, input logic dwr, input logic [1:0] sa,
        input logic sb, input logic ao, input logic ae, input logic bz, input logic hl,
        input logic [10:0] pc, input logic [10:0] op, input logic [15:0] cnt);
        return {16'd0, ird, drd, dwr, sa, sb, ao, ae, bz, hl, pc, op, cnt};
    endfunction

    function automatic logic [15:0] satInc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] expv);
        logic [63:0] obs;
        obs = packOut(instr_rd, data_rd, data_wr, sel_a, sel_b, alu_op, acc_en,
                      busy, halted, pc_addr, operand, cycle_count);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Drive start and advance to 1 ns after the next rising edge
    task automatic applyStimulus(input logic startVal);
        start = startVal;
        @(posedge clk);
        #1;
    endtask

    task automatic applyReset();
        rst_n = 1'b0;
        start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b0);
        mPc     = '0;
        mLastOp = '0;
        mCount  = '0;
        checkOutput("reset idle", packOut(0,0,0,2'd0,0,0,0,0,0, 11'd0, 11'd0, 16'd0));
    endtask

    // Reference model: one instruction expressed as its latency and per-cycle strobes
    task automatic runInstr(input string tag, output bit wasHalt);
        logic [15:0] ins;
        logic [4:0]  opc;
        logic [10:0] opd;
        bit          needMem;
        bit          isHlt;
        int          lat;
        logic        drd, dwr, sb, ao, ae;
        logic [1:0]  sa;
        ins     = progMem[mPc];
        opc     = ins[15:11];
        opd     = ins[10:0];
        isHlt   = (opc == 5'd0);
        needMem = (opc == 5'd2) || (opc == 5'd4) || (opc == 5'd6);
        lat     = isHlt ? 2 : (needMem ? 4 : 3);
        for (int k = 0; k < lat; k++) begin
            drd = 0; dwr = 0; sa = 2'd0; sb = 0; ao = 0; ae = 0;
            if (k == 1 && needMem) drd = 1;
            if (k == lat - 1 && !isHlt) begin
                case (opc)
                    5'd1: dwr = 1;
                    5'd2: begin sa = 2'd0; ae = 1; end
                    5'd3: begin sa = 2'd1; ae = 1; end
                    5'd4: begin sa = 2'd2; sb = 0; ao = 0; ae = 1; end
                    5'd5: begin sa = 2'd2; sb = 1; ao = 0; ae = 1; end
                    5'd6: begin sa = 2'd2; sb = 0; ao = 1; ae = 1; end
                    5'd7: begin sa = 2'd2; sb = 1; ao = 1; ae = 1; end
                    default: ;
                endcase
            end
            checkOutput($sformatf("%s pc=%0h k=%0d", tag, mPc, k),
                        packOut(k == 0, drd, dwr, sa, sb, ao, ae, 1'b1, 1'b0,
                                mPc, (k == 0) ? mLastOp : opd, mCount));
            applyStimulus(1'b0);
            mCount = satInc(mCount);
        end
        mLastOp = opd;
        if (!isHlt) mPc = mPc + 11'd1;
        wasHalt = isHlt;
    endtask

    task automatic runInstrs(input string tag, input int maxInstr, output bit sawHalt);
        bit h;
        sawHalt = 0;
        for (int i = 0; i < maxInstr; i++) begin
            runInstr(tag, h);
            if (h) begin
                sawHalt = 1;
                break;
            end
        end
    endtask

    initial begin
        bit h;
        instr_data = '0;
        start      = 1'b0;
        rst_n      = 1'b0;
        for (int i = 0; i < 2048; i++) progMem[i] = 16'h0000;

        // Program 1: LDI 5, ADDI 3, STO 0x010, HLT
        progMem[0] = 16'h1805; progMem[1] = 16'h2803;
        progMem[2] = 16'h0810; progMem[3] = 16'h0000;
        applyReset();
        applyStimulus(1'b1);
        runInstrs("prog1", 8, h);
        checkOutput("prog1 halt", packOut(0,0,0,2'd0,0,0,0,0,1, 11'd3, 11'd0, 16'd11));
        applyStimulus(1'b1);
        checkOutput("halt start pulse", packOut(0,0,0,2'd0,0,0,0,0,1, 11'd3, 11'd0, 16'd11));
        applyStimulus(1'b0);
        checkOutput("halt hold", packOut(0,0,0,2'd0,0,0,0,0,1, 11'd3, 11'd0, 16'd11));

        // Program 2: LD 4, SUB 2, SUBI 1, unknown opcode, HLT
        progMem[0] = 16'h1004; progMem[1] = 16'h3002; progMem[2] = 16'h3801;
        progMem[3] = 16'hF800; progMem[4] = 16'h0000;
        applyReset();
        applyStimulus(1'b1);
        runInstrs("prog2", 8, h);
        checkOutput("prog2 halt", packOut(0,0,0,2'd0,0,0,0,0,1, 11'd4, 11'd0, 16'd16));

        // Reset asserted during the MEM cycle of an LD
        applyReset();
        applyStimulus(1'b1);
        checkOutput("abort fetch", packOut(1,0,0,2'd0,0,0,0,1,0, 11'd0, 11'd0, 16'd0));
        applyStimulus(1'b0);
        checkOutput("abort decode", packOut(0,1,0,2'd0,0,0,0,1,0, 11'd0, 11'd4, 16'd1));
        applyStimulus(1'b0);
        checkOutput("abort mem", packOut(0,0,0,2'd0,0,0,0,1,0, 11'd0, 11'd4, 16'd2));
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("abort async", packOut(0,0,0,2'd0,0,0,0,0,0, 11'd0, 11'd0, 16'd0));
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b0);
        checkOutput("abort release", packOut(0,0,0,2'd0,0,0,0,0,0, 11'd0, 11'd0, 16'd0));

        // Random program of 30 non-halt instructions ending in HLT
        for (int i = 0; i < 30; i++)
            progMem[i] = {5'($urandom_range(1, 31)), 11'($urandom)};
        progMem[30] = 16'h0000;
        applyReset();
        applyStimulus(1'b1);
        runInstrs("rand", 40, h);
        checkOutput("rand halt", packOut(0,0,0,2'd0,0,0,0,0,1, 11'd30, 11'd0, mCount));

        // Long NOP run: PC wraps after 2048 instructions, counter saturates
        for (int i = 0; i < 2048; i++)
            progMem[i] = {5'($urandom_range(8, 31)), 11'($urandom)};
        applyReset();
        applyStimulus(1'b1);
        runInstrs("nop", 2048, h);
        checkOutput("pc wrap", packOut(1,0,0,2'd0,0,0,0,1,0, 11'd0, progMem[2047][10:0], 16'd6144));
        runInstrs("nop", 19852, h);
        checkOutput("count saturate", packOut(1,0,0,2'd0,0,0,0,1,0, mPc, mLastOp, 16'hFFFF));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bip_control.md
Name: bip_control

Overview:
Multi-cycle control unit for the accumulator-based BIP datapath of TP3. It fetches 16-bit instructions from program memory, decodes them, and drives the PC, the data-memory strobes, the accumulator-input mux, the ALU operation and the accumulator write enable. It sits between program memory, data memory and the datapath: accumulator register, ALU and operand muxes.

Parameters:
PC_WIDTH, 11, program counter and operand width; instr[10:0] is the operand.
OPCODE_WIDTH, 5, opcode field width; instr[15:11] is the opcode.
CNT_WIDTH, 16, width of the cycle counter.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  begins execution from PC=0 when in IDLE
instr_data  in  16  program memory read data; synchronous read, valid the cycle after instr_rd
instr_rd  out  1  program memory read strobe
pc_addr  out  PC_WIDTH  program memory address (current PC)
operand  out  PC_WIDTH  latched instr[10:0]; used as immediate and data address
data_rd  out  1  data memory read strobe; 1-cycle read latency
data_wr  out  1  data memory write strobe; write data is the accumulator
sel_a  out  2  accumulator input mux: 0 = data memory, 1 = immediate, 2 = ALU result
sel_b  out  1  ALU operand B: 0 = data memory, 1 = immediate
alu_op  out  1  0 = add, 1 = subtract
acc_en  out  1  accumulator load enable
busy  out  1  high in FETCH/DECODE/MEM/EXEC
halted  out  1  high in HALT
cycle_count  out  CNT_WIDTH  cycles spent in busy states; saturating

Behaviour:
- Reset (async, rst_n=0): state=IDLE, PC=0, instr register=0, cycle_count=0. All strobes, sel_a, sel_b, alu_op, busy and halted are 0. Deassertion is taken synchronously at the next clk edge.
- Opcodes: 00000 HLT, 00001 STO, 00010 LD, 00011 LDI, 00100 ADD, 00101 ADDI, 00110 SUB, 00111 SUBI. All other opcodes are NOP: PC+1, no strobes.
- FSM states: IDLE, FETCH, DECODE, MEM, EXEC, HALT.
- IDLE: waits for start=1, then goes to FETCH. start is ignored in every other state.
- FETCH: instr_rd=1 and pc_addr=PC. Next state is DECODE.
- DECODE: latch instr_data into the instr register.
  - HLT goes to HALT. PC is not incremented.
  - LD/ADD/SUB: data_rd=1 this cycle, with the data address taken from instr_data[10:0] combinationally. Next state is MEM.
  - All other opcodes go to EXEC.
- MEM: one wait cycle for read data. Next state is EXEC.
- EXEC: single-cycle strobes, then PC <= PC+1 (wraps 2^PC_WIDTH-1 -> 0) and next state is FETCH.
  - LD: sel_a=0, acc_en=1.
  - LDI: sel_a=1, acc_en=1.
  - ADD: sel_a=2, sel_b=0, alu_op=0, acc_en=1.
  - ADDI: sel_a=2, sel_b=1, alu_op=0, acc_en=1.
  - SUB/SUBI: same as ADD/ADDI with alu_op=1.
  - STO: data_wr=1, acc_en=0.
- Outside EXEC, acc_en, data_wr, sel_a, sel_b and alu_op are 0.
- Latency per instruction: immediate ops, STO and NOP take 3 cycles. LD/ADD/SUB take 4 cycles. HLT takes 2 cycles to reach HALT.
- HALT: absorbing state; only rst_n leaves it. PC and the instr register are frozen.
- cycle_count: increments every cycle while busy=1 and saturates at all ones.
- operand: always reflects the instr register.
- Reset asserted mid-instruction aborts immediately. No strobe may remain high after rst_n falls.

Decomposition:
- Package bip_pkg holds:
  - opcode localparams (OP_HLT..OP_SUBI);
  - sel_a encodings (SELA_MEM, SELA_IMM, SELA_ALU);
  - ALU_ADD/ALU_SUB;
  - state encoding.
- One natural sub-module, bip_decoder: purely combinational opcode -> {needs_mem, sel_a, sel_b, alu_op, acc_en, data_wr, is_halt}. The FSM, PC and counter stay in bip_control.

Test Plan:
- Reset then start=1 with program [0x1805 LDI 5, 0x2803 ADDI 3, 0x0810 STO 0x010, 0x0000 HLT] -> EXEC cycles show:
  - LDI: sel_a=1, acc_en=1;
  - ADDI: sel_a=2, sel_b=1, alu_op=0;
  - STO: data_wr=1 with operand=0x010;
  - then halted=1 with PC=3, and cycle_count=11.
- LD 0x004 (0x1004) -> data_rd=1 in DECODE with address 0x004, one MEM cycle, acc_en=1 with sel_a=0 in EXEC; 4 cycles total.
- SUB 0x002 (0x3002) and SUBI 1 (0x3801) -> alu_op=1 and sel_a=2 in EXEC; sel_b=0 for SUB, sel_b=1 for SUBI.
- Unknown opcode 0xF800 -> no strobes, PC advances by 1. Also preload PC=0x7FF with a NOP and check that PC wraps to 0x000.
- In HALT, pulse start=1 -> state and outputs unchanged. Assert rst_n=0 during a MEM cycle -> all outputs 0 immediately, and PC=0 after release.
- Force the cycle counter to 0xFFFE with a long NOP program -> it holds at 0xFFFF.
